// File: rtl/encoder_16x4_serial.sv
// Serialising 16-to-4 encoder: captures a multi-hot vector and emits the index of each set bit, lowest first.
// Latency: vector accepted at edge k gives its first out beat valid from edge k+1; one beat per cycle after that.
// Backpressure: out/out_valid/out_last hold while out_ready is low; in_ready is high only in IDLE.
// Optional macro ENC_COUNT_EN adds the registered 'remaining' beat-count output.
module encoder_16x4_serial #(
   parameter int N_IN  = 16,
   parameter int OUT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_IN-1:0]  in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             zero
`ifdef ENC_COUNT_EN
   ,
   output logic [OUT_W:0]   remaining
`endif
);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   localparam logic [N_IN-1:0] ONE_VEC = {{(N_IN-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [N_IN-1:0]  pend_q, pend_d;
   logic [N_IN-1:0]  pend_clr;
   logic [OUT_W-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             zero_q, zero_d;
`ifdef ENC_COUNT_EN
   logic [OUT_W:0]   rem_q, rem_d;
`endif

   // Lowest set bit wins: scan from MSB down so later (lower) hits overwrite.
   function automatic logic [OUT_W-1:0] lowest_idx(input logic [N_IN-1:0] v);
      logic [OUT_W-1:0] idx;
      idx = '0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         if (v[i]) idx = OUT_W'(i);
      end
      return idx;
   endfunction

   // True when exactly one bit of v is set.
   function automatic logic single_bit(input logic [N_IN-1:0] v);
      return (v != '0) && ((v & (v - ONE_VEC)) == '0);
   endfunction

`ifdef ENC_COUNT_EN
   function automatic logic [OUT_W:0] popcount(input logic [N_IN-1:0] v);
      logic [OUT_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < N_IN; i++) begin
         cnt = cnt + (OUT_W+1)'(v[i]);
      end
      return cnt;
   endfunction
`endif

   // Next-state and output-register logic for the IDLE/EMIT controller.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      zero_d      = 1'b0;
`ifdef ENC_COUNT_EN
      rem_d       = rem_q;
`endif
      // Pending set with the bit currently on 'out' removed.
      pend_clr         = pend_q;
      pend_clr[out_q]  = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (in == '0) begin
                  // Nothing to emit; just flag it for one cycle.
                  zero_d = 1'b1;
               end else begin
                  pend_d      = in;
                  out_d       = lowest_idx(in);
                  out_valid_d = 1'b1;
                  out_last_d  = single_bit(in);
                  state_d     = EMIT;
`ifdef ENC_COUNT_EN
                  rem_d       = popcount(in);
`endif
               end
            end
         end
         EMIT: begin
            if (out_valid_q && out_ready) begin
               pend_d = pend_clr;
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_d       = '0;
                  out_last_d  = 1'b0;
                  state_d     = IDLE;
`ifdef ENC_COUNT_EN
                  rem_d       = '0;
`endif
               end else begin
                  out_d      = lowest_idx(pend_clr);
                  out_last_d = single_bit(pend_clr);
`ifdef ENC_COUNT_EN
                  rem_d      = rem_q - (OUT_W+1)'(1);
`endif
               end
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any vector in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         zero_q      <= 1'b0;
`ifdef ENC_COUNT_EN
         rem_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         zero_q      <= zero_d;
`ifdef ENC_COUNT_EN
         rem_q       <= rem_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign zero      = zero_q;
`ifdef ENC_COUNT_EN
   assign remaining = rem_q;
`endif

endmodule

// File: tb/tb_encoder_16x4_serial.sv
// Directed bench for encoder_16x4_serial: reset, single/multi-hot, back-pressure, zero, full vector, mid-emit reset.
// Inputs change and outputs are sampled on the falling clock edge.
// Summary line reports total checks and errors.
module tb_encoder_16x4_serial;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  out;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        zero;
`ifdef ENC_COUNT_EN
   logic [4:0]  remaining;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   encoder_16x4_serial #(.N_IN(16), .OUT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .zero      (zero)
`ifdef ENC_COUNT_EN
      ,
      .remaining (remaining)
`endif
   );

   // Present one vector for a single cycle; returns at the falling edge after the accept edge.
   task automatic send_vec(input logic [15:0] v);
      in       = v;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in       = 16'h0000;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      in        = 16'h0000;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out !== 4'd0)       begin errors++; $display("FAIL reset_out got=%0d exp=0", out); end
      checks++; if (zero !== 1'b0)      begin errors++; $display("FAIL reset_zero got=%b exp=0", zero); end
      checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef ENC_COUNT_EN
      checks++; if (remaining !== 5'd0) begin errors++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single;
      out_ready = 1'b1;
      send_vec(16'h0001);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      checks++; if (out !== 4'd0)       begin errors++; $display("FAIL single_out got=%0d exp=0", out); end
      checks++; if (out_last !== 1'b1)  begin errors++; $display("FAIL single_last got=%b exp=1", out_last); end
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL single_in_ready_busy got=%b exp=0", in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_after_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL single_after_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_multi;
      logic [3:0] exp_idx [4];
      exp_idx[0] = 4'd0; exp_idx[1] = 4'd5; exp_idx[2] = 4'd10; exp_idx[3] = 4'd15;
      out_ready = 1'b1;
      send_vec(16'h8421);
      for (int k = 0; k < 4; k++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL multi_valid beat=%0d got=%b exp=1", k, out_valid); end
         checks++; if (out !== exp_idx[k]) begin errors++; $display("FAIL multi_out beat=%0d got=%0d exp=%0d", k, out, exp_idx[k]); end
         checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL multi_last beat=%0d got=%b exp=%b", k, out_last, (k == 3)); end
`ifdef ENC_COUNT_EN
         checks++; if (remaining !== 5'(4 - k)) begin errors++; $display("FAIL multi_remaining beat=%0d got=%0d exp=%0d", k, remaining, 4 - k); end
`endif
         @(negedge clk);
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL multi_end_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      send_vec(16'hC000);
      for (int k = 0; k < 3; k++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", k, out_valid); end
         checks++; if (out !== 4'd14)      begin errors++; $display("FAIL bp_hold_out cyc=%0d got=%0d exp=14", k, out); end
         checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL bp_hold_last cyc=%0d got=%b exp=0", k, out_last); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      checks++; if (out !== 4'd14)     begin errors++; $display("FAIL bp_beat0_out got=%0d exp=14", out); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_beat1_valid got=%b exp=1", out_valid); end
      checks++; if (out !== 4'd15)     begin errors++; $display("FAIL bp_beat1_out got=%0d exp=15", out); end
      checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL bp_beat1_last got=%b exp=1", out_last); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_zero;
      out_ready = 1'b1;
      send_vec(16'h0000);
      checks++; if (zero !== 1'b1)      begin errors++; $display("FAIL zero_pulse got=%b exp=1", zero); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_no_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL zero_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      checks++; if (zero !== 1'b0)      begin errors++; $display("FAIL zero_one_cycle got=%b exp=0", zero); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_later_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_full;
      int exp_i;
      exp_i = 0;
      out_ready = 1'b1;
      send_vec(16'hFFFF);
      for (int cyc = 0; cyc < 100; cyc++) begin
         out_ready = (cyc % 2 == 0);
         if (out_valid && out_ready) begin
            checks++; if (out !== 4'(exp_i)) begin errors++; $display("FAIL full_out beat=%0d got=%0d exp=%0d", exp_i, out, exp_i); end
            checks++; if (out_last !== (exp_i == 15)) begin errors++; $display("FAIL full_last beat=%0d got=%b exp=%b", exp_i, out_last, (exp_i == 15)); end
`ifdef ENC_COUNT_EN
            checks++; if (remaining !== 5'(16 - exp_i)) begin errors++; $display("FAIL full_remaining beat=%0d got=%0d exp=%0d", exp_i, remaining, 16 - exp_i); end
`endif
            exp_i++;
         end
         @(negedge clk);
         if (exp_i == 16) break;
      end
      checks++; if (exp_i != 16) begin errors++; $display("FAIL full_beat_count got=%0d exp=16", exp_i); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_end_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL full_end_in_ready got=%b exp=1", in_ready); end
`ifdef ENC_COUNT_EN
      checks++; if (remaining !== 5'd0) begin errors++; $display("FAIL full_end_remaining got=%0d exp=0", remaining); end
`endif
      out_ready = 1'b1;
   endtask

   task automatic test_reset_mid_emit;
      out_ready = 1'b1;
      send_vec(16'hFFFF);
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_valid got=%b exp=1", out_valid); end
      checks++; if (out !== 4'd3)       begin errors++; $display("FAIL rst_mid_out got=%0d exp=3", out); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_after_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_after_valid got=%b exp=0", out_valid); end
      // A fresh single-bit vector must produce exactly one beat: no stale pending bits.
      send_vec(16'h0001);
      checks++; if (out !== 4'd0)      begin errors++; $display("FAIL rst_fresh_out got=%0d exp=0", out); end
      checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL rst_fresh_last got=%b exp=1", out_last); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_fresh_end_valid got=%b exp=0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_backpressure();
      test_zero();
      test_full();
      test_reset_mid_emit();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/encoder_16x4_serial.md
Name: encoder_16x4_serial

Overview:
Registered 16-to-4 serialising encoder; the inverse of the team's 4x16 decoder. Captures a multi-hot 16-bit vector with a valid/ready handshake. Emits the 4-bit index of every set bit, one index per output handshake, lowest index first. Used to turn decoded select/request vectors back into binary codes for downstream logic.

Parameters:
N_IN, 16, input vector width; must equal 2**OUT_W.
OUT_W, 4, output code width.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in  input  N_IN  multi-hot vector to encode.
in_valid  input  1  producer asserts when `in` is valid.
in_ready  output  1  block can accept a vector this cycle.
out  output  OUT_W  binary index of the current set bit.
out_valid  output  1  `out` is valid.
out_ready  input  1  consumer accepts `out` this cycle.
out_last  output  1  current beat is the final set bit of the captured vector.
zero  output  1  one-cycle pulse: an all-zero vector was accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, pend=0, out=0, out_valid=0, out_last=0, zero=0. in_ready is 1 while in IDLE.
- All outputs are registered; in_ready is decoded from state (in_ready = state==IDLE).
- IDLE:
  - Accept on in_valid && in_ready.
  - If in==0: zero=1 for the next cycle only. Stay in IDLE; no out beat.
  - Else: pend<=in; go to EMIT.
  - In the cycle after accept: out_valid=1, out=index of lowest set bit of in, out_last=(popcount(in)==1).
- EMIT, on a beat (out_valid && out_ready):
  - Clear that bit in pend.
  - If out_last was 1: out_valid<=0, out<=0, out_last<=0, go to IDLE.
  - Else: out<=index of next lowest set bit; out_last<=(one bit remaining after the clear).
- Back-pressure: while out_valid && !out_ready, out, out_valid and out_last hold stable.
- in is ignored outside IDLE (in_ready=0).
- Latency: accept at edge k -> first beat valid from edge k+1.
- Throughput: one code per cycle while out_ready is held high.
- After the last beat there is exactly one IDLE cycle with in_ready=1 before the next capture can start emitting (no same-cycle reload).
- Bit 15 set is a legal value; the index saturates at 15 and does not wrap.
- Asserting rst_n mid-EMIT aborts the vector immediately; remaining pend bits are discarded.
- Priority encode: N_IN-bit scan, lowest index wins. Must be synthesisable combinational logic (for-loop from MSB to LSB with overwrite is acceptable).

Optional Feature:
Macro ENC_COUNT_EN.
- Defined: adds output port `remaining` (OUT_W+1 bits), registered.
  - On accept it loads popcount(in).
  - It decrements on each beat and reads 0 in IDLE.
  - It equals the number of beats left, including the current beat.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> out_valid=0, out=0, zero=0, in_ready=1. Pull rst_n low mid-EMIT on in=16'hFFFF -> out_valid drops asynchronously; after release in_ready=1 and pend is empty.
- Single bit: in=16'h0001, out_ready=1 -> one beat out=0, out_last=1. Next cycle out_valid=0, in_ready=1.
- Multi-hot: in=16'h8421, out_ready=1 -> consecutive beats out=0,5,10,15. out_last=1 only on 15.
- Back-pressure: in=16'hC000, out_ready=0 for 3 cycles -> out=14 held stable, out_valid=1. Then out_ready=1 -> beats 14 then 15 (out_last=1).
- Zero vector: in=16'h0000 accepted -> zero=1 for exactly one cycle, no out_valid, in_ready stays 1.
- Full vector: in=16'hFFFF, out_ready toggling 1/0 -> 16 beats, out=0..15 in order, none dropped or duplicated. With ENC_COUNT_EN, remaining reads 16,15,...,1 on the beats, then 0.
